hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Consumes the decode-stage Tuse/Tnew/destination outputs of the instruction controller.
//  Tracks in-flight writers through the E/M/W stages.
//  Issues the D-stage stall and the per-stage forwarding selects for the 5-stage MIPS pipeline.
//  Sits beside the datapath.
//  Its internal E/M/W shadow registers advance in lockstep with the datapath pipeline registers.
// PARAMETERS
//  REG_W    5   register-number width
//  CNT_W    32  stall-counter width
// PORTS
//  clk         in   1      pipeline clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  rs_d        in   5      Instr[25:21] of D-stage instruction
//  rt_d        in   5      Instr[20:16] of D-stage instruction
//  a3_d        in   5      resolved write register of D instr (0 = no write)
//  tuse_rsd    in   1      rs read in D (Tuse=0)
//  tuse_rtd    in   1      rt read in D (Tuse=0)
//  tuse_rse    in   1      rs read in E (Tuse=1)
//  tuse_rte    in   1      rt read in E (Tuse=1)
//  tuse_rtm    in   1      rt read in M (Tuse=2)
//  tnew_d      in   2      cycles until result ready, measured from D (0/2/3)
//  stall       out  1      hold PC and F/D reg, bubble into D/E reg
//  fwd_rs_d    out  2      00 RF, 01 E, 10 M, 11 W
//  fwd_rt_d    out  2      encoding as fwd_rs_d
//  fwd_rs_e    out  2      00 ID/EX value, 10 M, 11 W
//  fwd_rt_e    out  2      encoding as fwd_rs_e
//  fwd_rt_m    out  1      0 EX/MEM value, 1 W
//  stall_cnt   out  CNT_W  number of stall cycles since reset
// BEHAVIOUR
//  State: E{a3,tnew,rs,rt}, M{a3,tnew,rt}, W{a3}; all zero on reset.
//  Consequence of reset: stall=0, every fwd=0, stall_cnt=0.
//  Reset is async assert, sync release; mid-operation reset discards all tracked writers.
//  Each clk edge:
//   W <= M.a3
//   M <= {E.a3, sat(E.tnew-1), E.rt}
//   E <= stall ? bubble(all 0) : {a3_d, sat(tnew_d-1), rs_d, rt_d}
//   sat() saturates at 0; 2-bit arithmetic only.
//  tuse_rs = tuse_rsd ? 0 : tuse_rse ? 1 : 3 (unused); tuse_rt = rsd/rte/rtm -> 0/1/2, else 3.
//  stall_rs = rs_d!=0 & ((E.a3==rs_d & E.tnew>tuse_rs) | (M.a3==rs_d & M.tnew>tuse_rs)).
//  stall_rt is the same rule with rt_d and tuse_rt.
//  stall = stall_rs | stall_rt; combinational from state and D inputs.
//  Register 0 never matches, never stalls, never forwards.
//  Forward requires match, a3!=0, and producer tnew==0.
//  Priority is youngest first: D selects E>M>W; E selects M>W; M selects W.
//  stall_cnt increments by 1 on every edge where stall=1; wraps at 2^CNT_W-1 -> 0.
//  Simultaneous stall_rs and stall_rt counts once.
//  During stall, fwd_*_d still reflects current state; the datapath ignores the D result.
// TESTING
//  Reset: hold reset_n=0 with random inputs.
//   -> stall=0, all fwd=0, stall_cnt=0; release with no hazards -> stall stays 0.
//  lw $8 (a3_d=8,tnew_d=3), then beq rs_d=8 (tuse_rsd).
//   -> stall=1 for 2 cycles; 3rd cycle stall=0, fwd_rs_d=11; stall_cnt=2.
//  addu $9 (tnew_d=2), then addu rs_d=9 (tuse_rse).
//   -> stall=0; next cycle fwd_rs_e=10 (M).
//  lw $10 then sw rt_d=10 (tuse_rtm).
//   -> stall=0 throughout; sw in M gets fwd_rt_m=1.
//  Writers $11 in E, M and W with tnew 0, then a D read of $11.
//   -> fwd=01 (E wins). Same with a3=0 and rs_d=0 -> fwd=00, stall=0.
//  Pulse reset_n low while the lw->beq stall is active.
//   -> stall drops immediately, E/M/W cleared, stall_cnt=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage hazard info in, stall/forward selects out.
interface hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [REG_W-1:0] a3_d;
    logic             tuse_rsd;
    logic             tuse_rtd;
    logic             tuse_rse;
    logic             tuse_rte;
    logic             tuse_rtm;
    logic [1:0]       tnew_d;
    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic             fwd_rt_m;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_d, rt_d, a3_d, tuse_rsd, tuse_rtd, tuse_rse, tuse_rte, tuse_rtm, tnew_d,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
    );
    modport slave (
        input  rs_d, rt_d, a3_d, tuse_rsd, tuse_rtd, tuse_rse, tuse_rte, tuse_rtm, tnew_d,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks E/M/W writers of a 5-stage MIPS pipeline, issues D stall and forward selects.
module hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic               clk,
    input logic               reset_n,
    hazard_scoreboard_if.slave sb
);
    logic [REG_W-1:0] e_a3_q, e_rs_q, e_rt_q, m_a3_q, m_rt_q, w_a3_q;
    logic [REG_W-1:0] e_a3_d, e_rs_d, e_rt_d, m_a3_d, m_rt_d, w_a3_d;
    logic [1:0]       e_tnew_q, m_tnew_q, e_tnew_d, m_tnew_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tuse_rs, tuse_rt;
    logic             stall_rs, stall_rt, stall;

    always_comb begin
        tuse_rs = sb.tuse_rsd ? 2'd0 : sb.tuse_rse ? 2'd1 : 2'd3;
        tuse_rt = sb.tuse_rtd ? 2'd0 : sb.tuse_rte ? 2'd1 : sb.tuse_rtm ? 2'd2 : 2'd3;
        stall_rs = (sb.rs_d != '0) && ((e_a3_q == sb.rs_d && e_tnew_q > tuse_rs) ||
                                       (m_a3_q == sb.rs_d && m_tnew_q > tuse_rs));
        stall_rt = (sb.rt_d != '0) && ((e_a3_q == sb.rt_d && e_tnew_q > tuse_rt) ||
                                       (m_a3_q == sb.rt_d && m_tnew_q > tuse_rt));
        stall = stall_rs || stall_rt;
        sb.stall = stall;
        // Youngest ready producer wins; W results are always ready.
        sb.fwd_rs_d = (sb.rs_d == '0) ? 2'b00 :
                      (e_a3_q == sb.rs_d && e_tnew_q == 2'd0) ? 2'b01 :
                      (m_a3_q == sb.rs_d && m_tnew_q == 2'd0) ? 2'b10 :
                      (w_a3_q == sb.rs_d) ? 2'b11 : 2'b00;
        sb.fwd_rt_d = (sb.rt_d == '0) ? 2'b00 :
                      (e_a3_q == sb.rt_d && e_tnew_q == 2'd0) ? 2'b01 :
                      (m_a3_q == sb.rt_d && m_tnew_q == 2'd0) ? 2'b10 :
                      (w_a3_q == sb.rt_d) ? 2'b11 : 2'b00;
        sb.fwd_rs_e = (e_rs_q == '0) ? 2'b00 :
                      (m_a3_q == e_rs_q && m_tnew_q == 2'd0) ? 2'b10 :
                      (w_a3_q == e_rs_q) ? 2'b11 : 2'b00;
        sb.fwd_rt_e = (e_rt_q == '0) ? 2'b00 :
                      (m_a3_q == e_rt_q && m_tnew_q == 2'd0) ? 2'b10 :
                      (w_a3_q == e_rt_q) ? 2'b11 : 2'b00;
        sb.fwd_rt_m = (m_rt_q != '0) && (w_a3_q == m_rt_q);
        sb.stall_cnt = cnt_q;
        w_a3_d   = m_a3_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        m_rt_d   = e_rt_q;
        e_a3_d   = stall ? '0 : sb.a3_d;
        e_tnew_d = (stall || sb.tnew_d == 2'd0) ? 2'd0 : sb.tnew_d - 2'd1;
        e_rs_d   = stall ? '0 : sb.rs_d;
        e_rt_d   = stall ? '0 : sb.rt_d;
        cnt_d    = cnt_q + CNT_W'(stall);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            m_rt_q   <= '0;
            w_a3_q   <= '0;
            cnt_q    <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            m_rt_q   <= m_rt_d;
            w_a3_q   <= w_a3_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks of hazard_scoreboard against an issue-history model.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(5), .CNT_W(32)) sb_if ();
    hazard_scoreboard #(.REG_W(5), .CNT_W(32)) dut (.clk(clk), .reset_n(reset_n), .sb(sb_if.slave));

    // hist[i] is the instruction that left D (i+1) edges ago: 0=E, 1=M, 2=W.
    typedef struct {int a3; int tnew; int rs; int rt;} ins_t;
    ins_t hist[3];
    logic [31:0] mcnt;

    function automatic int tn(int i);
        return (hist[i].tnew > i + 1) ? hist[i].tnew - (i + 1) : 0;
    endfunction

    function automatic bit m_stall_reg(int r, int u);
        if (r == 0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (hist[i].a3 == r && tn(i) > u) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_fwd(int r, int first);
        if (r == 0) return 0;
        for (int i = first; i < 3; i++)
            if (hist[i].a3 == r && tn(i) == 0) return i + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        int urs, urt;
        urs = sb_if.tuse_rsd ? 0 : sb_if.tuse_rse ? 1 : 3;
        urt = sb_if.tuse_rtd ? 0 : sb_if.tuse_rte ? 1 : sb_if.tuse_rtm ? 2 : 3;
        return m_stall_reg(int'(sb_if.rs_d), urs) || m_stall_reg(int'(sb_if.rt_d), urt);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
        mcnt = 0;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        #1;
        chk({tag, ":stall"},    32'(sb_if.stall),    32'(m_stall()));
        chk({tag, ":fwd_rs_d"}, 32'(sb_if.fwd_rs_d), 32'(m_fwd(int'(sb_if.rs_d), 0)));
        chk({tag, ":fwd_rt_d"}, 32'(sb_if.fwd_rt_d), 32'(m_fwd(int'(sb_if.rt_d), 0)));
        chk({tag, ":fwd_rs_e"}, 32'(sb_if.fwd_rs_e), 32'(m_fwd(hist[0].rs, 1)));
        chk({tag, ":fwd_rt_e"}, 32'(sb_if.fwd_rt_e), 32'(m_fwd(hist[0].rt, 1)));
        chk({tag, ":fwd_rt_m"}, 32'(sb_if.fwd_rt_m), 32'(m_fwd(hist[1].rt, 2) != 0));
        chk({tag, ":cnt"},      sb_if.stall_cnt,     mcnt);
    endtask

    task automatic tick();
        bit   s;
        ins_t cur;
        s = m_stall();
        cur = '{int'(sb_if.a3_d), int'(sb_if.tnew_d), int'(sb_if.rs_d), int'(sb_if.rt_d)};
        @(posedge clk);
        if (!reset_n) clear_model();
        else begin
            if (s) mcnt = mcnt + 1;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = s ? '{0, 0, 0, 0} : cur;
        end
        #1;
    endtask

    task automatic drive(int rs, int rt, int a3, bit rsd, bit rtd, bit rse, bit rte, bit rtm, int tnew);
        sb_if.rs_d = 5'(rs);
        sb_if.rt_d = 5'(rt);
        sb_if.a3_d = 5'(a3);
        sb_if.tuse_rsd = rsd;
        sb_if.tuse_rtd = rtd;
        sb_if.tuse_rse = rse;
        sb_if.tuse_rte = rte;
        sb_if.tuse_rtm = rtm;
        sb_if.tnew_d = 2'(tnew);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive_rand(int maxr);
        int tsel;
        tsel = $urandom_range(0, 2);
        drive($urandom_range(0, maxr), $urandom_range(0, maxr), $urandom_range(0, maxr),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              tsel == 0 ? 0 : tsel + 1);
    endtask

    initial begin
        clear_model();
        idle();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand(31);
            check_all("reset");
            tick();
        end
        chk("reset_stall", 32'(sb_if.stall), 32'd0);
        chk("reset_cnt", sb_if.stall_cnt, 32'd0);
        reset_n = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            check_all("post_reset");
            tick();
        end
        chk("post_reset_stall", 32'(sb_if.stall), 32'd0);

        // lw $8 then beq reading $8 in D
        drive(0, 0, 8, 0, 0, 0, 0, 0, 3);
        check_all("lw8");
        tick();
        drive(8, 0, 0, 1, 0, 0, 0, 0, 0);
        check_all("beq_c1");
        chk("beq_stall1", 32'(sb_if.stall), 32'd1);
        tick();
        check_all("beq_c2");
        chk("beq_stall2", 32'(sb_if.stall), 32'd1);
        tick();
        check_all("beq_c3");
        chk("beq_stall3", 32'(sb_if.stall), 32'd0);
        chk("beq_fwd_w", 32'(sb_if.fwd_rs_d), 32'd3);
        chk("beq_cnt", sb_if.stall_cnt, 32'd2);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin check_all("drain1"); tick(); end

        // addu $9 then addu reading $9 in E
        drive(0, 0, 9, 0, 0, 0, 0, 0, 2);
        tick();
        drive(9, 0, 0, 0, 0, 1, 0, 0, 0);
        check_all("addu_c1");
        chk("addu_nostall", 32'(sb_if.stall), 32'd0);
        tick();
        idle();
        check_all("addu_c2");
        chk("addu_fwd_m", 32'(sb_if.fwd_rs_e), 32'd2);
        for (int i = 0; i < 3; i++) tick();

        // lw $10 then sw storing $10
        drive(0, 0, 10, 0, 0, 0, 0, 0, 3);
        tick();
        drive(0, 10, 0, 0, 0, 0, 0, 1, 0);
        check_all("sw_c1");
        chk("sw_nostall1", 32'(sb_if.stall), 32'd0);
        tick();
        idle();
        check_all("sw_c2");
        chk("sw_nostall2", 32'(sb_if.stall), 32'd0);
        tick();
        check_all("sw_c3");
        chk("sw_fwd_w", 32'(sb_if.fwd_rt_m), 32'd1);
        for (int i = 0; i < 2; i++) tick();

        // $11 in E, M and W, all ready
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 11, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(11, 11, 0, 1, 1, 0, 0, 0, 0);
        check_all("r11");
        chk("r11_rs_e_wins", 32'(sb_if.fwd_rs_d), 32'd1);
        chk("r11_rt_e_wins", 32'(sb_if.fwd_rt_d), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        check_all("r0");
        chk("r0_fwd", 32'(sb_if.fwd_rs_d), 32'd0);
        chk("r0_stall", 32'(sb_if.stall), 32'd0);
        tick();

        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 500; i++) begin
            drive_rand(i < 250 ? 3 : 31);
            check_all("rand");
            tick();
        end

        // reset pulse in the middle of a lw->beq stall
        idle();
        for (int i = 0; i < 3; i++) tick();
        drive(0, 0, 8, 0, 0, 0, 0, 0, 3);
        tick();
        drive(8, 0, 0, 1, 0, 0, 0, 0, 0);
        check_all("mid_c1");
        chk("mid_stall_before", 32'(sb_if.stall), 32'd1);
        #2;
        reset_n = 1'b0;
        clear_model();
        check_all("mid_rst");
        chk("mid_rst_stall", 32'(sb_if.stall), 32'd0);
        chk("mid_rst_cnt", sb_if.stall_cnt, 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive_rand(31);
            check_all("mid_hold");
            tick();
        end
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_all("mid_release");
            tick();
        end
        chk("mid_release_cnt", sb_if.stall_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
